// File: rtl/mixcolumns_iter.sv
`default_nettype none
// ============================================================================
// Module   : mixcolumns_iter
// Brief    : Iterative, handshaked AES MixColumns (forward/inverse) that
//            processes COLS_PER_CYCLE columns of a 128-bit state per clock.
// Revision : 1.0 - initial release
// ============================================================================
module mixcolumns_iter #(
    parameter int COLS_PER_CYCLE = 1,
    parameter bit INV_EN         = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         inv,
    input  logic [127:0] state,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out,
    output logic         busy
);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_busy = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;
    localparam logic [1:0] c_step    = 2'(COLS_PER_CYCLE);
    localparam logic [1:0] c_last    = 2'(4 - COLS_PER_CYCLE);

    if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
        $error("mixcolumns_iter: COLS_PER_CYCLE must be 1, 2 or 4");
    end

    logic [1:0]   r_state;
    logic [1:0]   w_state_nxt;
    logic [127:0] r_work;
    logic [127:0] w_next_work;
    logic         r_inv;
    logic [1:0]   r_cnt;
    logic [1:0]   w_idx     [COLS_PER_CYCLE];
    logic [31:0]  w_col_in  [COLS_PER_CYCLE];
    logic [31:0]  w_col_out [COLS_PER_CYCLE];

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Both directions share the x2/x4/x8 chain; inverse coefficients are sums of it.
    function automatic logic [31:0] mix_col(input logic [31:0] col, input logic inv_mode);
        logic [7:0]  a  [4];
        logic [7:0]  x2 [4];
        logic [7:0]  x4 [4];
        logic [7:0]  x8 [4];
        logic [7:0]  fwd_b;
        logic [7:0]  inv_b;
        logic [31:0] r;
        r = 32'h0;
        for (int i = 0; i < 4; i++) begin
            a[i]  = col[31-8*i -: 8];
            x2[i] = xtime(a[i]);
            x4[i] = xtime(x2[i]);
            x8[i] = xtime(x4[i]);
        end
        for (int i = 0; i < 4; i++) begin
            fwd_b = x2[i] ^ x2[(i+1)&3] ^ a[(i+1)&3] ^ a[(i+2)&3] ^ a[(i+3)&3];
            inv_b = (x8[i] ^ x4[i] ^ x2[i])
                  ^ (x8[(i+1)&3] ^ x2[(i+1)&3] ^ a[(i+1)&3])
                  ^ (x8[(i+2)&3] ^ x4[(i+2)&3] ^ a[(i+2)&3])
                  ^ (x8[(i+3)&3] ^ a[(i+3)&3]);
            r[31-8*i -: 8] = inv_mode ? inv_b : fwd_b;
        end
        return r;
    endfunction

    function automatic logic [31:0] get_col(input logic [127:0] work, input logic [1:0] idx);
        case (idx)
            2'd0:    return work[127:96];
            2'd1:    return work[95:64];
            2'd2:    return work[63:32];
            default: return work[31:0];
        endcase
    endfunction

    for (genvar j = 0; j < COLS_PER_CYCLE; j++) begin : g_col
        assign w_idx[j]     = r_cnt + 2'(j);
        assign w_col_in[j]  = get_col(r_work, w_idx[j]);
        assign w_col_out[j] = mix_col(w_col_in[j], r_inv);
    end

    always_comb begin
        w_next_work = r_work;
        for (int j = 0; j < COLS_PER_CYCLE; j++) begin
            case (w_idx[j])
                2'd0:    w_next_work[127:96] = w_col_out[j];
                2'd1:    w_next_work[95:64]  = w_col_out[j];
                2'd2:    w_next_work[63:32]  = w_col_out[j];
                default: w_next_work[31:0]   = w_col_out[j];
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: if (in_valid)        w_state_nxt = c_st_busy;
            c_st_busy: if (r_cnt == c_last) w_state_nxt = c_st_done;
            c_st_done: if (out_ready)       w_state_nxt = c_st_idle;
            default:                        w_state_nxt = c_st_idle;
        endcase
    end

    always_comb begin
        in_ready  = (r_state == c_st_idle);
        busy      = (r_state == c_st_busy);
        out_valid = (r_state == c_st_done);
    end

    // With the inverse path excluded, mode is pinned to forward at capture.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_work <= 128'h0;
            r_inv  <= 1'b0;
            r_cnt  <= 2'd0;
        end else if (r_state == c_st_idle && in_valid) begin
            r_work <= state;
            r_inv  <= inv && INV_EN;
            r_cnt  <= 2'd0;
        end else if (r_state == c_st_busy) begin
            r_work <= w_next_work;
            r_cnt  <= r_cnt + c_step;
        end
    end

    assign out = r_work;

endmodule
`default_nettype wire

// File: tb/tb_mixcolumns_iter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mixcolumns_iter
// Brief    : Self-checking bench for mixcolumns_iter (COLS 1/2/4, INV_EN 0/1).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mixcolumns_iter;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid  [4];
    logic         in_ready  [4];
    logic         inv       [4];
    logic         out_valid [4];
    logic         out_ready [4];
    logic         busy      [4];
    logic [127:0] st        [4];
    logic [127:0] out       [4];

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    // Instances 0..2: COLS_PER_CYCLE 1/2/4 with inverse; instance 3: COLS 1, no inverse.
    for (genvar g = 0; g < 4; g++) begin : g_dut
        mixcolumns_iter #(
            .COLS_PER_CYCLE((g == 3) ? 1 : (1 << g)),
            .INV_EN        ((g == 3) ? 1'b0 : 1'b1)
        ) u_dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .in_valid (in_valid[g]),
            .in_ready (in_ready[g]),
            .inv      (inv[g]),
            .state    (st[g]),
            .out_valid(out_valid[g]),
            .out_ready(out_ready[g]),
            .out      (out[g]),
            .busy     (busy[g])
        );
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Generic GF(2^8) multiply, reduction by 0x11B.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h0;
        logic       hi;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p ^= a;
            hi = a[7];
            a  = a << 1;
            if (hi) a ^= 8'h1b;
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [127:0] ref_mix(input logic [127:0] s, input logic iv);
        logic [7:0]   cf [4];
        logic [7:0]   acc;
        logic [127:0] r = 128'h0;
        if (iv) cf = '{8'd14, 8'd11, 8'd13, 8'd9};
        else    cf = '{8'd2, 8'd3, 8'd1, 8'd1};
        for (int c = 0; c < 4; c++) begin
            for (int i = 0; i < 4; i++) begin
                acc = 8'h0;
                for (int k = 0; k < 4; k++)
                    acc ^= gmul(s[127 - 8*(4*c + ((i+k)%4)) -: 8], cf[k]);
                r[127 - 8*(4*c + i) -: 8] = acc;
            end
        end
        return r;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input int u, input logic [127:0] s, input logic iv);
        int n = 0;
        while (!in_ready[u] && n < 100) begin
            tick();
            n++;
        end
        check("accept_ready", in_ready[u], 1'b1);
        in_valid[u] = 1'b1;
        st[u]       = s;
        inv[u]      = iv;
        tick();
        in_valid[u] = 1'b0;
        st[u]       = rnd128();
        inv[u]      = ~iv;
    endtask

    // Latency counts the accept edge as cycle 1.
    task automatic wait_out(input int u, output int lat);
        lat = 1;
        while (!out_valid[u] && lat < 60) begin
            tick();
            lat++;
        end
        check("out_valid_seen", out_valid[u], 1'b1);
    endtask

    task automatic stream(input int u);
        logic [127:0] q[$];
        logic [127:0] exp;
        int sent = 0, recv = 0, cyc = 0;
        logic acc;
        while (recv < 8 && cyc < 3000) begin
            if (!in_valid[u]) inv[u] = 1'($urandom);
            if (!in_valid[u] && sent < 8 && ($urandom % 3) != 0) begin
                in_valid[u] = 1'b1;
                st[u]       = rnd128();
                inv[u]      = 1'($urandom);
            end
            acc = in_valid[u] && in_ready[u];
            if (acc) begin
                q.push_back(ref_mix(st[u], inv[u]));
                sent++;
            end
            out_ready[u] = 1'($urandom);
            if (out_valid[u] && out_ready[u]) begin
                if (q.size() == 0) begin
                    check("stream_extra", out_valid[u], 1'b0);
                end else begin
                    exp = q.pop_front();
                    check("stream_data", out[u], exp);
                end
                recv++;
            end
            tick();
            if (acc) in_valid[u] = 1'b0;
            cyc++;
        end
        check("stream_count", 128'(recv), 128'd8);
        check("stream_left", 128'(q.size()), 128'd0);
        in_valid[u]  = 1'b0;
        out_ready[u] = 1'b1;
        tick();
        tick();
    endtask

    localparam logic [127:0] c_a = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
    localparam logic [127:0] c_b = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
    localparam logic [127:0] c_c = 128'h00010203_04050607_d4d4d4d5_2d26314c;
    localparam logic [127:0] c_d = 128'h02070005_06030401_d5d5d7d6_4d7ebdf8;

    initial begin
        int           lat;
        logic [127:0] r;
        logic [127:0] exp;
        rst_n = 1'b0;
        for (int u = 0; u < 4; u++) begin
            in_valid[u]  = 1'b0;
            inv[u]       = 1'b0;
            st[u]        = 128'h0;
            out_ready[u] = 1'b1;
        end
        tick(); tick(); tick();
        for (int u = 0; u < 4; u++) begin
            check("rst_out_valid", out_valid[u], 1'b0);
            check("rst_in_ready", in_ready[u], 1'b1);
            check("rst_busy", busy[u], 1'b0);
            check("rst_out", out[u], 128'h0);
        end
        rst_n = 1'b1;
        tick();

        // Forward, one column per clock
        accept(0, c_a, 1'b0);
        check("fwd1_busy", busy[0], 1'b1);
        wait_out(0, lat);
        check("fwd1_lat", 128'(lat), 128'd5);
        check("fwd1_out", out[0], c_b);
        tick();
        check("fwd1_idle_ready", in_ready[0], 1'b1);
        check("fwd1_idle_valid", out_valid[0], 1'b0);

        // Inverse, two columns per clock
        accept(1, c_b, 1'b1);
        wait_out(1, lat);
        check("inv2_lat", 128'(lat), 128'd3);
        check("inv2_out", out[1], c_a);
        tick();

        // Byte order, four columns per clock
        accept(2, c_c, 1'b0);
        wait_out(2, lat);
        check("fwd4_lat", 128'(lat), 128'd2);
        check("fwd4_out", out[2], c_d);
        tick();

        // Backpressure with an ignored input pulse
        out_ready[0] = 1'b0;
        r   = rnd128();
        exp = ref_mix(r, 1'b0);
        accept(0, r, 1'b0);
        wait_out(0, lat);
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                in_valid[0] = 1'b1;
                st[0]       = rnd128();
                inv[0]      = 1'b1;
            end
            check("bp_out", out[0], exp);
            check("bp_valid", out_valid[0], 1'b1);
            check("bp_in_ready", in_ready[0], 1'b0);
            tick();
        end
        out_ready[0] = 1'b1;
        tick();
        check("bp_release_ready", in_ready[0], 1'b1);
        check("bp_release_valid", out_valid[0], 1'b0);
        check("bp_not_accepted", busy[0], 1'b0);
        in_valid[0] = 1'b0;
        tick();
        check("bp_still_idle", busy[0], 1'b0);

        // Reset in the middle of BUSY
        accept(1, rnd128(), 1'b0);
        rst_n = 1'b0;
        tick();
        check("rst_mid_valid", out_valid[1], 1'b0);
        check("rst_mid_out", out[1], 128'h0);
        check("rst_mid_ready", in_ready[1], 1'b1);
        check("rst_mid_busy", busy[1], 1'b0);
        rst_n = 1'b1;
        accept(1, {16{8'h01}}, 1'($urandom));
        wait_out(1, lat);
        check("rst_after_out", out[1], {16{8'h01}});
        tick();

        // Inverse path excluded: inv is ignored
        r = rnd128();
        accept(3, r, 1'b1);
        wait_out(3, lat);
        check("noinv_lat", 128'(lat), 128'd5);
        check("noinv_out", out[3], ref_mix(r, 1'b0));
        tick();

        for (int u = 0; u < 3; u++) stream(u);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
